// File: rtl/chose_1to2_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: FSM encodings,
// default widths and the routing helper.
package chose_1to2_stream_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_CNT_W = 8;
  localparam int NUM_OUT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT0 = 2'd1,
    ST_PKT1 = 2'd2
  } state_e;

  // Destination is only taken from sel while no packet is open.
  function automatic logic route_of(input state_e st, input logic sel);
    case (st)
      ST_PKT0: route_of = 1'b0;
      ST_PKT1: route_of = 1'b1;
      default: route_of = sel;
    endcase
  endfunction

endpackage

// File: rtl/chose_out_slot.sv
// One-entry output pipeline register with valid/ready handshake and an
// optional completed-packet counter (CHOSE_1TO2_CNT_EN).
module chose_out_slot
  import chose_1to2_stream_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DW-1:0]    data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
`ifdef CHOSE_1TO2_CNT_EN
  output logic [CNT_W-1:0] pkts_o,
`endif
  output logic             last_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          last_q;

  assign can_load_o = !valid_q || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef CHOSE_1TO2_CNT_EN
  logic [CNT_W-1:0] pkts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                pkts_q <= '0;
    else if (valid_q && ready_i && last_q)    pkts_q <= pkts_q + 1'b1;
  end

  assign pkts_o = pkts_q;
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/chose_1to2_stream.sv
// 1-to-2 packet demultiplexer: route picked on a packet's first beat and held
// to its last beat. Optional per-output packet counters via CHOSE_1TO2_CNT_EN.
module chose_1to2_stream
  import chose_1to2_stream_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_data_i,
  input  logic             in_last_i,
  input  logic             in_sel_i,
  output logic             out0_valid_o,
  input  logic             out0_ready_i,
  output logic [DW-1:0]    out0_data_o,
  output logic             out0_last_o,
  output logic             out1_valid_o,
  input  logic             out1_ready_i,
  output logic [DW-1:0]    out1_data_o,
`ifdef CHOSE_1TO2_CNT_EN
  output logic [CNT_W-1:0] out0_pkts_o,
  output logic [CNT_W-1:0] out1_pkts_o,
`endif
  output logic             out1_last_o
);

  state_e                        state_q;
  logic                          route;
  logic                          accept;
  logic [NUM_OUT-1:0]            slot_load;
  logic [NUM_OUT-1:0]            slot_can;
  logic [NUM_OUT-1:0]            slot_rdy;
  logic [NUM_OUT-1:0]            slot_vld;
  logic [NUM_OUT-1:0]            slot_last;
  logic [NUM_OUT-1:0][DW-1:0]    slot_data;

  assign route      = route_of(state_q, in_sel_i);
  assign in_ready_o = slot_can[route];
  assign accept     = in_valid_i && in_ready_o;
  assign slot_rdy   = {out1_ready_i, out0_ready_i};
  assign slot_load  = {accept && route, accept && !route};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else if (accept) begin
      if (in_last_i)              state_q <= ST_IDLE;
      else if (state_q == ST_IDLE) state_q <= in_sel_i ? ST_PKT1 : ST_PKT0;
    end
  end

`ifdef CHOSE_1TO2_CNT_EN
  logic [NUM_OUT-1:0][CNT_W-1:0] slot_pkts;
  assign out0_pkts_o = slot_pkts[0];
  assign out1_pkts_o = slot_pkts[1];
`endif

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_slot
    chose_out_slot #(.DW(DW), .CNT_W(CNT_W)) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (slot_load[n]),
      .data_i     (in_data_i),
      .last_i     (in_last_i),
      .ready_i    (slot_rdy[n]),
      .can_load_o (slot_can[n]),
      .valid_o    (slot_vld[n]),
      .data_o     (slot_data[n]),
`ifdef CHOSE_1TO2_CNT_EN
      .pkts_o     (slot_pkts[n]),
`endif
      .last_o     (slot_last[n])
    );
  end

  assign out0_valid_o = slot_vld[0];
  assign out0_data_o  = slot_data[0];
  assign out0_last_o  = slot_last[0];
  assign out1_valid_o = slot_vld[1];
  assign out1_data_o  = slot_data[1];
  assign out1_last_o  = slot_last[1];

endmodule

// File: tb/tb_chose_1to2_stream.sv
// Directed bench for chose_1to2_stream; the counter scenario runs only when
// CHOSE_1TO2_CNT_EN is defined.
module tb_chose_1to2_stream;

  localparam int DW    = 8;
  localparam int CNT_W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, in_sel;
  logic [DW-1:0] in_data;
  logic          out0_valid, out0_ready, out0_last;
  logic          out1_valid, out1_ready, out1_last;
  logic [DW-1:0] out0_data, out1_data;
`ifdef CHOSE_1TO2_CNT_EN
  logic [CNT_W-1:0] out0_pkts, out1_pkts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chose_1to2_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .in_sel_i     (in_sel),
    .out0_valid_o (out0_valid),
    .out0_ready_i (out0_ready),
    .out0_data_o  (out0_data),
    .out0_last_o  (out0_last),
    .out1_valid_o (out1_valid),
    .out1_ready_i (out1_ready),
    .out1_data_o  (out1_data),
`ifdef CHOSE_1TO2_CNT_EN
    .out0_pkts_o  (out0_pkts),
    .out1_pkts_o  (out1_pkts),
`endif
    .out1_last_o  (out1_last)
  );

  // Present one beat, clock it, return 1 time unit after the edge.
  task automatic beat(input logic [DW-1:0] d, input logic s, input logic l);
    in_valid = 1'b1; in_data = d; in_sel = s; in_last = l;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL rst_out0_valid got %0b exp 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rst_out1_valid got %0b exp 0", out1_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    checks++; if (out0_data !== 8'h00 || out0_last !== 1'b0) begin errors++; $display("FAIL rst_out0_data got %h/%b exp 00/0", out0_data, out0_last); end
`ifdef CHOSE_1TO2_CNT_EN
    checks++; if (out0_pkts !== 8'd0 || out1_pkts !== 8'd0) begin errors++; $display("FAIL rst_pkts got %0d/%0d exp 0/0", out0_pkts, out1_pkts); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat;
    beat(8'hA5, 1'b0, 1'b1);
    in_valid = 1'b0;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA5 || out0_last !== 1'b1) begin errors++; $display("FAIL single_out0 got v%b d%h l%b exp v1 dA5 l1", out0_valid, out0_data, out0_last); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL single_out1_valid got %b exp 0", out1_valid); end
    idle(1);
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out0_valid); end
  endtask

  task automatic test_sel_hold;
    logic [DW-1:0] exp_d [3];
    logic          sels  [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    sels[0] = 1'b1;   sels[1] = 1'b0;   sels[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(exp_d[i], sels[i], i == 2);
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== exp_d[i] || out1_last !== (i == 2) || out0_valid !== 1'b0) begin
        errors++;
        $display("FAIL sel_hold_beat%0d got out1 v%b d%h l%b out0 v%b exp v1 d%h", i, out1_valid, out1_data, out1_last, out0_valid, exp_d[i]);
      end
    end
    idle(1);
  endtask

  task automatic test_stall;
    out0_ready = 1'b0;
    beat(8'h40, 1'b0, 1'b0);
    in_data = 8'h41; in_last = 1'b1; in_sel = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h40 || out0_last !== 1'b0) begin errors++; $display("FAIL stall_hold got v%b d%h l%b exp v1 d40 l0", out0_valid, out0_data, out0_last); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stall_no_leak got out1_valid %b exp 0", out1_valid); end
    out0_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h41 || out0_last !== 1'b1) begin errors++; $display("FAIL stall_second got v%b d%h l%b exp v1 d41 l1", out0_valid, out0_data, out0_last); end
    idle(1);
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out0_valid); end
  endtask

  task automatic test_unrouted;
    out0_ready = 1'b0;
    beat(8'h55, 1'b0, 1'b1);
    in_data = 8'h66; in_sel = 1'b1; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unrouted_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h66) begin errors++; $display("FAIL unrouted_out1 got v%b d%h exp v1 d66", out1_valid, out1_data); end
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h55) begin errors++; $display("FAIL unrouted_out0_held got v%b d%h exp v1 d55", out0_valid, out0_data); end
    idle(1);
    checks++; if (out1_valid !== 1'b0 || out0_valid !== 1'b1) begin errors++; $display("FAIL unrouted_drain got out1 v%b out0 v%b exp 0/1", out1_valid, out0_valid); end
    out0_ready = 1'b1;
    idle(1);
  endtask

  task automatic test_reset_mid;
    beat(8'h71, 1'b0, 1'b0);
    beat(8'h72, 1'b0, 1'b0);
    in_valid = 1'b0;
    out0_ready = 1'b0;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h72) begin errors++; $display("FAIL mid_pre got v%b d%h exp v1 d72", out0_valid, out0_data); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== 8'h00) begin errors++; $display("FAIL mid_clear got v%b/%b d%h exp 0/0 d00", out0_valid, out1_valid, out0_data); end
    out0_ready = 1'b1;
    beat(8'h99, 1'b1, 1'b1);
    in_valid = 1'b0;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h99 || out0_valid !== 1'b0) begin errors++; $display("FAIL mid_reroute got out1 v%b d%h out0 v%b exp v1 d99 v0", out1_valid, out1_data, out0_valid); end
    idle(1);
  endtask

`ifdef CHOSE_1TO2_CNT_EN
  task automatic test_wrap;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 255; i++) beat(i[7:0], 1'b1, 1'b1);
    idle(1);
    checks++; if (out1_pkts !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", out1_pkts); end
    beat(8'hFF, 1'b1, 1'b1);
    idle(1);
    checks++; if (out1_pkts !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", out1_pkts); end
    checks++; if (out0_pkts !== 8'd0) begin errors++; $display("FAIL wrap_out0 got %0d exp 0", out0_pkts); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_beat;
    test_sel_hold;
    test_stall;
    test_unrouted;
    test_reset_mid;
`ifdef CHOSE_1TO2_CNT_EN
    test_wrap;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
